// File: rtl/pe_operand_fifo.sv
// Operand buffer between a connection box and a PE input: bypass, single
// register, or ready/valid FIFO, selected through the shared config bus.
module pe_operand_fifo #(
  parameter int          WIDTH    = 16,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] CFG_ADDR = 32'd0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                config_addr,
  input  logic [31:0]                config_data,
  input  logic                       config_en,
  output logic [31:0]                read_data,
  input  logic [WIDTH-1:0]           in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ModeBypass = 2'd0,
    ModeReg    = 2'd1,
    ModeFifo   = 2'd2,
    ModeRsvd   = 2'd3
  } mode_e;

  mode_e            cfg_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] out_reg_q;
  logic             vld_reg_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic cfgHit, cfgWrite, flush;
  logic fifoEmpty, fifoFull, push, pop;
  logic unusedCfgBits;

  assign unusedCfgBits = ^config_data[31:3];

  assign cfgHit   = (config_addr == CFG_ADDR);
  assign cfgWrite = config_en & cfgHit;
  // Any mode change, or the explicit strobe bit, discards everything buffered.
  assign flush    = cfgWrite & ((config_data[1:0] != cfg_q) | config_data[2]);

  assign read_data = cfgHit ? {30'b0, cfg_q} : 32'b0;

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == CW'(DEPTH));
  assign push      = (cfg_q == ModeFifo) & in_valid & ~fifoFull;
  assign pop       = (cfg_q == ModeFifo) & ~fifoEmpty & out_ready;

  always_comb begin
    out       = in;
    out_valid = in_valid;
    in_ready  = out_ready;
    count     = '0;
    case (cfg_q)
      ModeReg: begin
        out       = out_reg_q;
        out_valid = vld_reg_q;
        in_ready  = 1'b1;
      end
      ModeFifo: begin
        out       = fifoEmpty ? '0 : mem_q[rd_ptr_q];
        out_valid = ~fifoEmpty;
        in_ready  = ~fifoFull;
        count     = count_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q     <= ModeBypass;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_reg_q <= '0;
      vld_reg_q <= 1'b0;
    end else begin
      if (cfgWrite) begin
        cfg_q <= mode_e'(config_data[1:0]);
      end
      if (cfg_q == ModeReg) begin
        out_reg_q <= in;
      end
      if (flush) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        count_q   <= '0;
        vld_reg_q <= 1'b0;
      end else begin
        if (cfg_q == ModeReg) begin
          vld_reg_q <= in_valid;
        end
        if (push) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage is not reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= in;
    end
  end

endmodule

// File: tb/tb_pe_operand_fifo.sv
// Directed bench for pe_operand_fifo: reset, register mode, FIFO fill/drain,
// wrap with simultaneous push/pop, flush and asynchronous reset.
module tb_pe_operand_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] config_addr, config_data, read_data;
  logic        config_en;
  logic [15:0] in, out;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  count;

  int totalChecks = 0;
  int badChecks   = 0;

  pe_operand_fifo #(.WIDTH(16), .DEPTH(4), .CFG_ADDR(32'd0)) dut (
    .clk(clk), .reset(reset),
    .config_addr(config_addr), .config_data(config_data),
    .config_en(config_en), .read_data(read_data),
    .in(in), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic v,
                               input logic r);
    in        = d;
    in_valid  = v;
    out_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeCfg(input logic [31:0] d);
    config_data = d;
    config_en   = 1'b1;
    tick();
    config_en   = 1'b0;
    config_data = 32'd0;
  endtask

  initial begin
    reset = 1'b1; config_addr = 32'd0; config_data = 32'd0; config_en = 1'b0;
    in = 16'd0; in_valid = 1'b0; out_ready = 1'b0;

    // Reset asserted mid-cycle, before any edge
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_rdata", read_data, 32'd0);
    applyStimulus(16'd4, 1'b1, 1'b1);
    checkOutput("rst_out", 32'(out), 32'd4);
    checkOutput("rst_vld", 32'(out_valid), 32'd1);
    checkOutput("rst_rdy", 32'(in_ready), 32'd1);
    applyStimulus(16'd4, 1'b1, 1'b0);
    checkOutput("byp_rdy_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(16'd0, 1'b0, 1'b0);
    tick();

    // Register mode
    writeCfg(32'd1);
    checkOutput("reg_rdata", read_data, 32'd1);
    config_addr = 32'd5;
    #1;
    checkOutput("reg_rdata_other", read_data, 32'd0);
    config_addr = 32'd0;
    applyStimulus(16'd345, 1'b1, 1'b0);
    checkOutput("reg_vld_before", 32'(out_valid), 32'd0);
    checkOutput("reg_rdy", 32'(in_ready), 32'd1);
    tick();
    checkOutput("reg_out", 32'(out), 32'd345);
    checkOutput("reg_vld", 32'(out_valid), 32'd1);
    applyStimulus(16'd0, 1'b0, 1'b0);
    tick();
    checkOutput("reg_vld_drop", 32'(out_valid), 32'd0);

    // FIFO fill and drain
    writeCfg(32'd2);
    checkOutput("fifo_rdata", read_data, 32'd2);
    checkOutput("fifo_empty_vld", 32'(out_valid), 32'd0);
    checkOutput("fifo_empty_out", 32'(out), 32'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(16'(10 + k), 1'b1, 1'b0);
      tick();
      if (k == 0) checkOutput("fifo_first_out", 32'(out), 32'd10);
    end
    checkOutput("fifo_full_count", 32'(count), 32'd4);
    checkOutput("fifo_full_rdy", 32'(in_ready), 32'd0);
    applyStimulus(16'd14, 1'b1, 1'b0);
    tick();
    checkOutput("fifo_fifth_push", 32'(count), 32'd4);
    applyStimulus(16'd0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("drain_out", 32'(out), 32'(10 + k));
      checkOutput("drain_vld", 32'(out_valid), 32'd1);
      tick();
    end
    checkOutput("drained_vld", 32'(out_valid), 32'd0);
    checkOutput("drained_out", 32'(out), 32'd0);
    checkOutput("drained_count", 32'(count), 32'd0);

    // Simultaneous push/pop across pointer wrap
    applyStimulus(16'd20, 1'b1, 1'b0);
    tick();
    applyStimulus(16'd21, 1'b1, 1'b0);
    tick();
    checkOutput("pp_count_start", 32'(count), 32'd2);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(16'(22 + k), 1'b1, 1'b1);
      checkOutput("pp_out", 32'(out), 32'(20 + k));
      checkOutput("pp_vld", 32'(out_valid), 32'd1);
      tick();
      checkOutput("pp_count", 32'(count), 32'd2);
    end

    // Flush strobe with a push pending in the same cycle
    applyStimulus(16'd30, 1'b1, 1'b0);
    tick();
    checkOutput("fl_count3", 32'(count), 32'd3);
    applyStimulus(16'd99, 1'b1, 1'b0);
    writeCfg(32'd6);
    applyStimulus(16'd0, 1'b0, 1'b0);
    checkOutput("fl_count", 32'(count), 32'd0);
    checkOutput("fl_vld", 32'(out_valid), 32'd0);
    checkOutput("fl_rdata", read_data, 32'd2);

    // Mode change empties buffered data
    applyStimulus(16'd40, 1'b1, 1'b0);
    tick();
    applyStimulus(16'd41, 1'b1, 1'b0);
    tick();
    applyStimulus(16'd0, 1'b0, 1'b0);
    checkOutput("mc_count_before", 32'(count), 32'd2);
    writeCfg(32'd1);
    checkOutput("mc_vld", 32'(out_valid), 32'd0);
    writeCfg(32'd2);
    checkOutput("mc_fifo_count", 32'(count), 32'd0);
    checkOutput("mc_fifo_vld", 32'(out_valid), 32'd0);

    // Reserved mode behaves as bypass
    writeCfg(32'd3);
    applyStimulus(16'd77, 1'b1, 1'b1);
    checkOutput("rsvd_out", 32'(out), 32'd77);
    checkOutput("rsvd_vld", 32'(out_valid), 32'd1);
    checkOutput("rsvd_rdata", read_data, 32'd3);

    // Asynchronous reset mid-operation
    writeCfg(32'd2);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(16'(50 + k), 1'b1, 1'b0);
      tick();
    end
    applyStimulus(16'd0, 1'b0, 1'b0);
    checkOutput("ar_count3", 32'(count), 32'd3);
    #2 reset = 1'b0;
    #1;
    checkOutput("ar_count", 32'(count), 32'd0);
    checkOutput("ar_rdata", read_data, 32'd0);
    checkOutput("ar_vld", 32'(out_valid), 32'd0);
    applyStimulus(16'd7, 1'b1, 1'b1);
    checkOutput("ar_out", 32'(out), 32'd7);
    reset = 1'b1;
    tick();
    checkOutput("ar_after_out", 32'(out), 32'd7);
    checkOutput("ar_after_rdata", read_data, 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/pe_operand_fifo.md
# pe_operand_fifo

Configurable operand buffer between a connection box output and a PE data input. It takes the 16-bit word selected by the connection box and delivers it to the PE in one of three configured modes: combinational bypass, a single pipeline register, or a ready/valid FIFO that absorbs PE stalls. It uses the same 32-bit configuration bus as the connection box, so both blocks are programmed in the same configuration pass.

## Interface
- WIDTH, 16, data width; must match the connection box width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CFG_ADDR, 0, value of config_addr that selects this block's configuration register.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- config_addr  input  32  configuration address.
- config_data  input  32  configuration write data.
- config_en  input  1  configuration write strobe.
- read_data  output  32  configuration readback.
- in  input  WIDTH  operand from the connection box.
- in_valid  input  1  `in` holds a valid word.
- in_ready  output  1  block accepts `in` this cycle.
- out  output  WIDTH  operand to the PE.
- out_valid  output  1  `out` holds a valid word.
- out_ready  input  1  PE consumes `out` this cycle.
- count  output  $clog2(DEPTH)+1  FIFO occupancy; 0 outside FIFO mode.

## Operation
- **Config write.** A write occurs when config_en=1 and config_addr==CFG_ADDR at a rising edge.
  - cfg[1:0] ← config_data[1:0] (mode).
  - config_data[2] is a flush strobe. It is not stored and always reads back 0.
- **Readback.** read_data = {30'b0, cfg[1:0]} when config_addr==CFG_ADDR, else 0. It is combinational from the stored register.
- **Modes.**
  - 0 bypass: out=in, out_valid=in_valid, in_ready=out_ready. No storage is used.
  - 1 register: out_reg←in and vld_reg←in_valid every cycle. out=out_reg, out_valid=vld_reg, in_ready=1. There is no backpressure and out_ready is ignored.
  - 2 FIFO: circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits and wrapping modulo DEPTH.
  - 3 reserved: behaves exactly as mode 0.
- **FIFO rules (mode 2).**
  - push = in_valid & in_ready, where in_ready = (count != DEPTH).
  - pop = out_valid & out_ready, where out_valid = (count != 0) and out = mem[rd_ptr].
  - Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal at any count except that push is not accepted when full (in_ready=0 even if out_ready=1).
  - No fall-through: a word pushed into an empty FIFO appears on out the next cycle.
  - out is 0 when empty.
- **Flush.** Flush clears wr_ptr, rd_ptr, count and vld_reg. It happens on any config write that changes mode, or on any config write with config_data[2]=1. It takes effect at the same edge as the write. A push or pop in that cycle is discarded.
- **Reset (reset=0, asynchronous).** cfg=0 (bypass), pointers=0, count=0, out_reg=0, vld_reg=0. Memory contents are don't-care. After reset, out, out_valid and in_ready follow bypass mode. Reset asserted mid-transfer drops all buffered words.

## Timing
- Latency in → out:
  - mode 0: 0 cycles.
  - mode 1: 1 cycle.
  - mode 2: 1 cycle when empty; otherwise after all earlier entries have been popped.
- FIFO mode sustains a throughput of 1 word/cycle when out_ready is held at 1.
- A config write is visible on read_data the cycle after the edge. The new mode governs the datapath from that same cycle.
- All outputs are combinational from registered state, except in mode 0/3, where they are combinational from in, in_valid and out_ready.

## Test plan
- **Reset/readback.** Assert reset=0 mid-cycle.
  - Required: count=0, read_data=0, out tracks in. in=4, in_valid=1 → out=4, out_valid=1 in the same cycle.
- **Register mode.** Write config_data=1; drive in=345, in_valid=1.
  - Required: out=345, out_valid=1 exactly one edge later.
  - With in_valid=0 the next cycle, out_valid=0 one edge after that.
- **FIFO fill and drain.** Write config_data=2; hold out_ready=0; push 10, 11, 12, 13.
  - Required: count=4, in_ready=0, and a fifth push of 14 is not accepted.
  - Set out_ready=1: out reads 10, 11, 12, 13 on successive cycles, then out_valid=0 and out=0.
- **Simultaneous push/pop and wrap.** With count=2, push and pop together for 6 cycles.
  - Required: count stays 2, order is preserved across pointer wrap, and out_valid stays 1.
- **Flush.** With count=3, write config_data=6 (mode 2 plus flush bit).
  - Required: count=0 and out_valid=0 next cycle; read_data=2.
  - Switching to mode 1 with data buffered also empties the FIFO.
- **Async reset mid-operation.** With count=3 in FIFO mode, pulse reset=0 between edges.
  - Required: count=0 and read_data=0 immediately, without waiting for a clock edge; the block returns to bypass mode.
